// File: rtl/chip_6502_bus_trace.sv
// Bus-cycle trace capture for the 6502 external bus: arm, address trigger with
// post-trigger window, record FIFO drained through a registered valid/ready port.
module chip_6502_bus_trace #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic        phi0,
  input  logic        res,
  input  logic [15:0] ab,
  input  logic [7:0]  db,
  input  logic        rw,
  input  logic        sync,
  input  logic        arm,
  input  logic        trig_en,
  input  logic [15:0] trig_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [41:0] out_data,
  output logic [1:0]  state,
  output logic        triggered,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic        triggered_q;
  logic        overflow_q;
  logic [15:0] stamp_q;
  logic [15:0] post_cnt_q;

  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic        out_valid_q, out_valid_d;
  logic [41:0] out_data_q;
  logic [41:0] mem [DEPTH];

  logic        capture, pop, full, fifo_empty, push_ok, trig_hit, arm_ok;
  logic [41:0] record;

  always_comb begin
    capture    = (state_q == S_ARMED) || (state_q == S_POST);
    pop        = out_valid_q && out_ready;
    full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    fifo_empty = (wr_q == rd_q);
    push_ok    = capture && (!full || pop);
    trig_hit   = trig_en && (ab == trig_addr);
    arm_ok     = arm && ((state_q == S_IDLE) || ((state_q == S_DONE) && fifo_empty));
    record     = {stamp_q, sync, rw, ab, db};
    wr_d       = wr_q + {{AW{1'b0}}, push_ok};
    rd_d       = rd_q + {{AW{1'b0}}, pop};
    // The head entry is held in the output register; a push this cycle shows up one edge later.
    out_valid_d = (wr_q != rd_d);
  end

  always_ff @(posedge phi0) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= record;
  end

  always_ff @(posedge phi0) begin
    if (res) begin
      wr_q        <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      if (out_valid_d) out_data_q <= mem[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge phi0) begin
    if (res) begin
      state_q     <= S_IDLE;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
      stamp_q     <= '0;
      post_cnt_q  <= '0;
    end else begin
      // Stamp advances even on a dropped push so that drops leave a visible gap.
      if (capture) begin
        stamp_q <= stamp_q + 16'd1;
        if (!push_ok) overflow_q <= 1'b1;
      end
      case (state_q)
        S_ARMED: begin
          if (trig_hit) begin
            triggered_q <= 1'b1;
            post_cnt_q  <= 16'(POST_TRIG);
            state_q     <= (POST_TRIG == 0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          post_cnt_q <= post_cnt_q - 16'd1;
          if (post_cnt_q == 16'd1) state_q <= S_DONE;
        end
        default: begin
          if (arm_ok) begin
            state_q     <= S_ARMED;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            stamp_q     <= '0;
          end
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign state     = state_q;
  assign triggered = triggered_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_chip_6502_bus_trace.sv
// Self-checking bench for chip_6502_bus_trace: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_chip_6502_bus_trace;

  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 8;

  logic        phi0 = 1'b0;
  logic        res = 1'b1;
  logic [15:0] ab = '0;
  logic [7:0]  db = '0;
  logic        rw = 1'b1;
  logic        sync = 1'b0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic [15:0] trig_addr = 16'h0FFF;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [41:0] out_data;
  logic [1:0]  state;
  logic        triggered;
  logic        overflow;

  chip_6502_bus_trace #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .phi0(phi0), .res(res), .ab(ab), .db(db), .rw(rw), .sync(sync),
    .arm(arm), .trig_en(trig_en), .trig_addr(trig_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .state(state), .triggered(triggered), .overflow(overflow)
  );

  always #5 phi0 = ~phi0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of records plus the capture rules as plain variables.
  logic [41:0] mq[$];
  int          m_state = 0;
  logic [15:0] m_stamp = '0;
  int          m_left  = 0;
  bit          m_trig  = 0;
  bit          m_ovf   = 0;
  bit          m_valid = 0;
  logic [41:0] m_data  = '0;

  logic [41:0] got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int size0;
    bit cap;
    if (res) begin
      mq.delete();
      m_state = 0; m_stamp = '0; m_left = 0; m_trig = 0; m_ovf = 0;
      m_valid = 0; m_data = '0;
      return;
    end
    size0 = mq.size();
    cap   = (m_state == 1) || (m_state == 2);
    if (m_valid && out_ready) void'(mq.pop_front());
    m_valid = (mq.size() > 0);
    if (m_valid) m_data = mq[0];
    if (cap) begin
      if (mq.size() < DEPTH) mq.push_back({m_stamp, sync, rw, ab, db});
      else m_ovf = 1;
      m_stamp = m_stamp + 16'd1;
    end
    case (m_state)
      1: if (trig_en && ab == trig_addr) begin
           m_trig = 1;
           if (POST_TRIG == 0) m_state = 3;
           else begin m_state = 2; m_left = POST_TRIG; end
         end
      2: begin
           m_left--;
           if (m_left == 0) m_state = 3;
         end
      default: if (arm && (m_state == 0 || size0 == 0)) begin
           m_state = 1; m_trig = 0; m_ovf = 0; m_stamp = '0;
         end
    endcase
  endtask

  task automatic tick();
    if (out_valid && out_ready) got.push_back(out_data);
    model_edge();
    @(posedge phi0);
    #1;
    chk("state", 64'(state), 64'(m_state));
    chk("triggered", 64'(triggered), 64'(m_trig));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) chk("out_data", 64'(out_data), 64'(m_data));
  endtask

  task automatic do_reset();
    res = 1'b1; arm = 1'b0;
    tick(); tick();
    res = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
    got.delete();
  endtask

  task automatic chk_stamps(input string name, input int n);
    chk({name, "_count"}, 64'(got.size()), 64'(n));
    if (got.size() == n)
      for (int k = 0; k < n; k++) chk({name, "_stamp"}, 64'(got[k][41:26]), 64'(k));
  endtask

  typedef struct {
    logic        res, arm, te;
    logic [15:0] ta, ab;
    logic [7:0]  db;
    logic        rw, sync, rdy;
    logic        e_valid;
    logic [1:0]  e_state;
    logic        e_trig, e_ovf;
    logic [41:0] e_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0FFF, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 42'd0};
    vecs[1] = vecs[0];
    vecs[2] = '{1'b0, 1'b0, 1'b0, 16'h0FFF, 16'h1234, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 42'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0FFF, 16'h0FFF, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 42'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0FFF, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 42'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h0FFF, 16'h1000, 8'hA0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 42'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'h0FFF, 16'h1001, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0,
                {16'd0, 1'b1, 1'b1, 16'h1000, 8'hA0}};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h0FFF, 16'h1002, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0,
                {16'd1, 1'b0, 1'b0, 16'h1001, 8'hA1}};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 16'h0FFF, 16'h2000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0,
                {16'd2, 1'b0, 1'b1, 16'h1002, 8'hA2}};

    // Reset defaults, idle bus activity, then streaming.
    for (int i = 0; i < 9; i++) begin
      res = vecs[i].res; arm = vecs[i].arm; trig_en = vecs[i].te; trig_addr = vecs[i].ta;
      ab = vecs[i].ab; db = vecs[i].db; rw = vecs[i].rw; sync = vecs[i].sync; out_ready = vecs[i].rdy;
      tick();
      chk("vec_valid", 64'(out_valid), 64'(vecs[i].e_valid));
      chk("vec_state", 64'(state), 64'(vecs[i].e_state));
      chk("vec_trig", 64'(triggered), 64'(vecs[i].e_trig));
      chk("vec_ovf", 64'(overflow), 64'(vecs[i].e_ovf));
      if (vecs[i].e_valid) chk("vec_data", 64'(out_data), 64'(vecs[i].e_data));
    end

    // Trigger window: match on 5th capture cycle, a second match inside POST is ignored.
    do_reset();
    trig_en = 1'b1; trig_addr = 16'h0FFF; out_ready = 1'b1;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      ab = (i == 4 || i == 7) ? 16'h0FFF : 16'h3000 + 16'(i);
      db = 8'($urandom);
      tick();
    end
    chk("trigwin_state", 64'(state), 64'd3);
    chk("trigwin_trig", 64'(triggered), 64'd1);
    chk_stamps("trigwin", 13);
    if (got.size() == 13) begin
      chk("trigwin_ab4", 64'(got[4][23:8]), 64'h0FFF);
      chk("trigwin_ab0", 64'(got[0][23:8]), 64'h3000);
    end

    // Overflow: consumer stalled for 20 capture cycles, trigger ends capture.
    do_reset();
    trig_en = 1'b1; out_ready = 1'b0;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      ab = (i == 11) ? 16'h0FFF : 16'h4000 + 16'(i);
      tick();
    end
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_state", 64'(state), 64'd3);
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk_stamps("ovf_drain", 16);

    // Full FIFO with concurrent pop: no drop, contiguous stamps.
    do_reset();
    trig_en = 1'b0; out_ready = 1'b0;
    do_arm();
    for (int i = 0; i < 16; i++) begin ab = 16'h5000 + 16'(i); tick(); end
    chk("full_noovf", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin ab = 16'h6000 + 16'(i); tick(); end
    trig_en = 1'b1; ab = 16'h0FFF; tick();
    trig_en = 1'b0;
    for (int i = 0; i < 28; i++) begin ab = 16'h7000 + 16'(i); tick(); end
    chk("fullpop_ovf", 64'(overflow), 64'd0);
    chk_stamps("fullpop", 35);

    // Reset mid-POST, arm refused in DONE while non-empty, re-arm after draining.
    do_reset();
    trig_en = 1'b1; out_ready = 1'b1;
    do_arm();
    for (int i = 0; i < 3; i++) begin ab = 16'h2222; tick(); end
    ab = 16'h0FFF; tick();
    ab = 16'h2223;
    for (int i = 0; i < 3; i++) tick();
    chk("post_before_res", 64'(state), 64'd2);
    res = 1'b1; tick(); res = 1'b0;
    chk("res_state", 64'(state), 64'd0);
    chk("res_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    do_arm();
    ab = 16'h0FFF; tick();
    ab = 16'h2224;
    for (int i = 0; i < 8; i++) tick();
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rearm_busy", 64'(state), 64'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("drained", 64'(out_valid), 64'd0);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rearm_ok", 64'(state), 64'd1);
    got.delete();
    ab = 16'h5555; trig_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rearm_count", 64'(got.size() > 0), 64'd1);
    if (got.size() > 0) begin
      chk("rearm_stamp0", 64'(got[0][41:26]), 64'd0);
      chk("rearm_ab", 64'(got[0][23:8]), 64'h5555);
    end

    // Randomized traffic against the reference model.
    do_reset();
    trig_addr = 16'h0ABC;
    for (int i = 0; i < 4000; i++) begin
      res       = ($urandom_range(0, 299) == 0);
      arm       = ($urandom_range(0, 9) == 0);
      trig_en   = ($urandom_range(0, 3) != 0);
      ab        = ($urandom_range(0, 11) == 0) ? trig_addr : 16'($urandom);
      db        = 8'($urandom);
      rw        = 1'($urandom);
      sync      = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chip_6502_bus_trace.md
# chip_6502_bus_trace

Bus-cycle trace capture that sits directly downstream of the 6502 core's external bus (`ab`, `db`, `rw`, `sync`). It samples one record per `phi0` cycle into an internal FIFO once armed. An address-match trigger followed by a fixed post-trigger window ends capture. Records drain through a valid/ready port to a logger or host, replacing ad-hoc address-match `$stop` probes with a synthesizable monitor.

## Interface
- `DEPTH`, 16: FIFO depth in records; power of two, ≥2.
- `POST_TRIG`, 8: records captured after the trigger record; 0..65535.
- `phi0` in 1: clock; all state updates on rising edge.
- `res` in 1: reset; synchronous, active-high.
- `ab` in 16: core address bus, sampled each capture cycle.
- `db` in 8: core data bus (read or write data), sampled each capture cycle.
- `rw` in 1: core read/write, 1 = read.
- `sync` in 1: core opcode-fetch indicator.
- `arm` in 1: start-capture request, level sampled per cycle.
- `trig_en` in 1: enables address trigger.
- `trig_addr` in 16: trigger address.
- `out_valid` out 1: `out_data` holds a record.
- `out_ready` in 1: consumer accepts the record when `out_valid` is also high.
- `out_data` out 42: record `{stamp[15:0], sync, rw, ab[15:0], db[7:0]}`.
- `state` out 2: 0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE.
- `triggered` out 1: sticky; trigger seen since the last accepted arm.
- `overflow` out 1: sticky; at least one record dropped since the last accepted arm.

## Operation
- **Reset** (`res` = 1 at an edge):
  - state IDLE; FIFO empty.
  - `out_valid`, `out_data`, `triggered`, `overflow` = 0; stamp = 0; post counter = 0.
  - Overrides everything, including mid-POST and mid-drain.
- **IDLE**: no capture. `arm` = 1 moves to ARMED and clears `triggered`, `overflow` and stamp.
- **ARMED**:
  - Push one record every cycle.
  - If `trig_en` and `ab == trig_addr`, push that cycle's record, set `triggered`, load the post counter with `POST_TRIG`, and go to POST.
  - If `POST_TRIG` = 0, go directly to DONE instead.
  - `arm` is ignored.
- **POST**:
  - Push one record per cycle and decrement the counter.
  - The cycle that pushes with counter = 1 moves to DONE.
  - Further address matches are ignored.
- **DONE**:
  - No capture; drain continues.
  - `arm` = 1 is accepted only when the FIFO is empty, and acts as in IDLE. Otherwise it is ignored.
- **Stamp**:
  - 16-bit counter; increments every cycle in ARMED/POST.
  - Wraps 0xFFFF → 0x0000.
  - The first record after arm carries stamp 0.
  - Stamps are assigned whether or not the push succeeds, so a drop shows as a stamp gap.
- **FIFO**:
  - Pointers are log2(DEPTH)+1 bits.
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - A rejected push drops the new record and sets `overflow`; stored records are never overwritten.
  - Pop occurs when `out_valid` && `out_ready`.
  - Simultaneous push and pop on an empty FIFO: no pop occurs (`out_valid` = 0), and the push is accepted.

## Timing
- `arm` high at edge k: `state` = ARMED after edge k. First sampled bus values are those present at edge k+1.
- A record is pushed at edge n. It appears on `out_data` with `out_valid` = 1 after edge n+1 (1-cycle latency, registered output).
- Trigger record sampled at edge t: `state` = POST after t (or DONE if `POST_TRIG` = 0), and `triggered` = 1 after t. The last post record is sampled at edge t+`POST_TRIG`, and `state` = DONE after that edge.
- With `out_ready` held high, throughput is 1 record/cycle and no overflow occurs.
- `out_data` is stable while `out_valid` = 1 and `out_ready` = 0.
- `state`, `triggered` and `overflow` are registered; none are combinational from inputs.

## Test plan
- **Reset defaults**: hold `res` 2 cycles, then release → `out_valid` = 0, `state` = 0, `triggered` = 0, `overflow` = 0. Toggling the bus without `arm` produces no records.
- **Streaming**: arm with `trig_en` = 0 and `out_ready` = 1, drive `ab` = 0x1000, 0x1001, 0x1002 → records appear 1 cycle later with stamps 0, 1, 2 and matching `ab`/`db`/`rw`/`sync`.
- **Trigger window**: `trig_addr` = 0x0FFF, `POST_TRIG` = 8, drive `ab` = 0x0FFF at the 5th capture cycle → exactly 13 records (stamps 0..12; `ab` = 0x0FFF at stamp 4), `triggered` = 1, `state` = 3, no further records.
- **Overflow**: `DEPTH` = 16, `out_ready` = 0, 20 armed cycles → `overflow` = 1. Then `out_ready` = 1 → exactly 16 records, stamps 0..15.
- **Full with concurrent pop**: fill the FIFO, then hold `out_ready` = 1 while still armed → `overflow` stays 0 and stamps emerge contiguous.
- **Reset and re-arm**:
  - Assert `res` mid-POST → `state` = 0, `out_valid` = 0 next cycle.
  - In DONE with a non-empty FIFO, `arm` = 1 → state stays 3.
  - After draining, `arm` = 1 → state goes to 1, stamp restarts at 0.
